// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : div_pkg
//  Purpose  : Shared types and constants for the restoring divider.
//             - state_t        : divider control states (IDLE, BUSY, DONE)
//             - DIV_WIDTH      : default operand width
//             - CNT_W          : step-counter width for the default width
//             - DIV0_QUOTIENT  : quotient returned for a zero divisor
//             - cla4()         : one 4-bit carry-look-ahead slice
//  Revision : 1.0 - initial release
// ============================================================================
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIV_WIDTH = 8;
    localparam int CNT_W     = $clog2(DIV_WIDTH);
    localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;

    // 4-bit carry-look-ahead adder slice. Returns {carry_out, sum[3:0]}.
    // All carries are formed directly from generate/propagate terms so the
    // slice has no internal ripple.
    function automatic logic [4:0] cla4(input logic [3:0] a,
                                        input logic [3:0] b,
                                        input logic       cin);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
        return {c[4], p ^ c[3:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/cla_sub.sv
`default_nettype none
// ============================================================================
//  Module   : cla_sub
//  Purpose  : N-bit subtractor with borrow-out, built from chained 4-bit
//             carry-look-ahead slices. Computes i_a + ~i_b + 1.
//  Ports    : i_a      [N-1:0]  minuend
//             i_b      [N-1:0]  subtrahend
//             o_diff   [N-1:0]  i_a - i_b (modulo 2^N)
//             o_borrow          1 when i_a < i_b
//  Revision : 1.0 - initial release
// ============================================================================
module cla_sub
    import div_pkg::*;
#(
    parameter int N = 9
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_diff,
    output logic         o_borrow
);

    localparam int c_slices = (N + 3) / 4;
    localparam int c_pad_w  = c_slices * 4;

    logic [c_pad_w-1:0] w_a_pad;
    logic [c_pad_w-1:0] w_b_inv;
    logic [c_pad_w-1:0] w_sum;
    logic [c_slices:0]  w_c;
    logic               w_unused_hi;

    // Both operands are zero-extended before inversion. The carry out of the
    // padded width then equals "a >= b", the same as at N bits.
    always_comb begin
        w_a_pad        = '0;
        w_a_pad[N-1:0] = i_a;
        w_b_inv        = '1;
        w_b_inv[N-1:0] = ~i_b;
    end

    assign w_c[0] = 1'b1;

    for (genvar s = 0; s < c_slices; s++) begin : g_slice
        assign {w_c[s+1], w_sum[4*s +: 4]} = cla4(w_a_pad[4*s +: 4],
                                                  w_b_inv[4*s +: 4],
                                                  w_c[s]);
    end

    assign o_diff      = w_sum[N-1:0];
    assign o_borrow    = ~w_c[c_slices];
    assign w_unused_hi = ^w_sum[c_pad_w-1:N];

endmodule
`default_nettype wire

// File: rtl/restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module   : restoring_divider
//  Purpose  : Multi-cycle unsigned integer divider, one restoring
//             shift/subtract step per clock, valid/ready on both sides.
//  Ports    : clk, rst_n            clock / async active-low reset
//             in_valid, in_ready    operand handshake
//             dividend, divisor     [WIDTH-1:0] operands (sampled at accept)
//             out_valid, out_ready  result handshake
//             quotient, remainder   [WIDTH-1:0] result
//             div_zero              divisor was zero for this result
//             is_signed             (only with DIVIDER_SIGNED_EN) two's
//                                   complement truncating division
//  Config   : `define DIVIDER_SIGNED_EN adds the is_signed port and one
//             negation cycle for signed operations.
//  Revision : 1.0 - initial release
// ============================================================================
module restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef DIVIDER_SIGNED_EN
    input  logic             is_signed,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int c_cnt_w = $clog2(WIDTH);

    state_t             r_state;
    logic [WIDTH-1:0]   r_rem;      // partial remainder; always < divisor
    logic [WIDTH-1:0]   r_q;        // dividend shifting out / quotient in
    logic [WIDTH-1:0]   r_d;        // divisor magnitude
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_dz;       // zero divisor captured at accept

    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_diff;
    logic               w_borrow;
    logic [WIDTH:0]     w_rem_nx;
    logic [WIDTH-1:0]   w_q_nx;
    logic [WIDTH-1:0]   w_dvd_mag;
    logic [WIDTH-1:0]   w_dvs_mag;
    logic               w_unused_rem_msb;
    logic               w_last_step;

`ifdef DIVIDER_SIGNED_EN
    logic               r_is_signed;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_fix;      // pending sign fix-up cycle
    logic               w_dvd_neg;
    logic               w_dvs_neg;

    assign w_dvd_neg = is_signed & dividend[WIDTH-1];
    assign w_dvs_neg = is_signed & divisor[WIDTH-1];
    // Most-negative maps onto itself, which read unsigned is its magnitude.
    assign w_dvd_mag = w_dvd_neg ? -dividend : dividend;
    assign w_dvs_mag = w_dvs_neg ? -divisor  : divisor;
`else
    assign w_dvd_mag = dividend;
    assign w_dvs_mag = divisor;
`endif

    // One restoring step: shift {R,Q} left, trial-subtract D from R.
    assign w_rem_sh = {r_rem, r_q[WIDTH-1]};

    cla_sub #(
        .N (WIDTH + 1)
    ) u_sub (
        .i_a      (w_rem_sh),
        .i_b      ({1'b0, r_d}),
        .o_diff   (w_diff),
        .o_borrow (w_borrow)
    );

    assign w_rem_nx    = w_borrow ? w_rem_sh : w_diff;
    assign w_q_nx      = {r_q[WIDTH-2:0], ~w_borrow};
    assign w_last_step = (r_cnt == c_cnt_w'(WIDTH - 1));
    // The restored remainder is below the divisor, so its top bit is zero.
    assign w_unused_rem_msb = w_rem_nx[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            r_rem     <= '0;
            r_q       <= '0;
            r_d       <= '0;
            r_cnt     <= '0;
            r_dz      <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            r_is_signed <= 1'b0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_fix       <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        r_state  <= BUSY;
                        r_rem    <= '0;
                        r_cnt    <= '0;
`ifdef DIVIDER_SIGNED_EN
                        r_is_signed <= is_signed;
                        r_neg_q     <= w_dvd_neg ^ w_dvs_neg;
                        r_neg_r     <= w_dvd_neg;
                        r_fix       <= 1'b0;
`endif
                        if (divisor == '0) begin
                            // Raw dividend is kept to be returned as remainder.
                            r_dz <= 1'b1;
                            r_q  <= dividend;
                            r_d  <= '0;
                        end else begin
                            r_dz <= 1'b0;
                            r_q  <= w_dvd_mag;
                            r_d  <= w_dvs_mag;
                        end
                    end
                end

                BUSY: begin
                    if (r_dz) begin
                        // Zero divisor spends a single cycle here to format
                        // the fixed result.
                        quotient  <= {WIDTH{1'b1}};
                        remainder <= r_q;
                        div_zero  <= 1'b1;
                        out_valid <= 1'b1;
                        r_state   <= DONE;
`ifdef DIVIDER_SIGNED_EN
                    end else if (r_fix) begin
                        quotient  <= r_neg_q ? -r_q   : r_q;
                        remainder <= r_neg_r ? -r_rem : r_rem;
                        div_zero  <= 1'b0;
                        out_valid <= 1'b1;
                        r_fix     <= 1'b0;
                        r_state   <= DONE;
`endif
                    end else begin
                        r_rem <= w_rem_nx[WIDTH-1:0];
                        r_q   <= w_q_nx;
                        r_cnt <= r_cnt + c_cnt_w'(1);
                        if (w_last_step) begin
`ifdef DIVIDER_SIGNED_EN
                            if (r_is_signed) begin
                                r_fix <= 1'b1;
                            end else begin
                                quotient  <= w_q_nx;
                                remainder <= w_rem_nx[WIDTH-1:0];
                                div_zero  <= 1'b0;
                                out_valid <= 1'b1;
                                r_state   <= DONE;
                            end
`else
                            quotient  <= w_q_nx;
                            remainder <= w_rem_nx[WIDTH-1:0];
                            div_zero  <= 1'b0;
                            out_valid <= 1'b1;
                            r_state   <= DONE;
`endif
                        end
                    end
                end

                DONE: begin
                    // in_ready stays low here so no operand is accepted on
                    // the DONE->IDLE edge.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= IDLE;
                    end
                end

                default: begin
                    r_state   <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_restoring_divider
//  Purpose  : Self-checking bench for restoring_divider (WIDTH = 8).
//             Stimulus pushes expected results into a queue; an independent
//             monitor pops and compares on every out_valid & out_ready.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_restoring_divider;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;
    logic         is_signed;
    logic         rand_bp;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    restoring_divider #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef DIVIDER_SIGNED_EN
        .is_signed (is_signed),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    // Reference model: plain integer arithmetic.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sgn);
        exp_t e;
        int   sa, sb_i, qi, ri;
        if (b == 0) begin
            e.q  = {W{1'b1}};
            e.r  = a;
            e.dz = 1'b1;
        end else if (sgn) begin
            sa   = int'($signed(a));
            sb_i = int'($signed(b));
            qi   = sa / sb_i;
            ri   = sa % sb_i;
            e.q  = W'(qi);
            e.r  = W'(ri);
            e.dz = 1'b0;
        end else begin
            e.q  = W'(int'(a) / int'(b));
            e.r  = W'(int'(a) % int'(b));
            e.dz = 1'b0;
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every presented-and-taken result is matched against the queue.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got q=%0h r=%0h, expected none",
                         quotient, remainder);
            end else begin
                e = sb.pop_front();
                check("quotient",  32'(quotient),  32'(e.q));
                check("remainder", 32'(remainder), 32'(e.r));
                check("div_zero",  32'(div_zero),  32'(e.dz));
            end
        end
    end

    // Random backpressure on the result side.
    always @(posedge clk) begin
        if (rand_bp) begin
            #2 out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    // Issue one operation, record its expectation and measure latency from
    // the accepting edge to the first out_valid.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sgn);
        int   guard;
        int   lat;
        int   exp_lat;
        @(posedge clk);
        #2;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk);
            #2;
            guard++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
            return;
        end
        in_valid  = 1'b1;
        dividend  = a;
        divisor   = b;
        is_signed = sgn;
        @(posedge clk);
        sb.push_back(model(a, b, sgn));
        #2;
        in_valid  = 1'b0;
        dividend  = W'($urandom);
        divisor   = W'($urandom);
        is_signed = 1'b0;
        lat = 0;
        forever begin
            @(negedge clk);
            if (out_valid || lat > 40) break;
            lat++;
        end
        if (b == 0) begin
            exp_lat = 1;
        end else begin
            exp_lat = W;
`ifdef DIVIDER_SIGNED_EN
            if (sgn) exp_lat = W + 1;
`endif
        end
        check("latency", 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

    initial begin
        exp_t hold;
        logic sgn;
        logic [W-1:0] a, b;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        dividend  = '0;
        divisor   = '0;
        out_ready = 1'b1;
        is_signed = 1'b0;
        rand_bp   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_quotient",  32'(quotient),  32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_div_zero",  32'(div_zero),  32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Reset in the middle of a division discards it.
        @(posedge clk);
        #2;
        in_valid = 1'b1;
        dividend = 8'd200;
        divisor  = 8'd7;
        @(posedge clk);
        #2 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("busy_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready",  32'(in_ready),  32'd1);
        check("midrst_quotient",  32'(quotient),  32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Directed cases.
        do_op(8'd200, 8'd7, 1'b0);
        do_op(8'd255, 8'd1, 1'b0);
        do_op(8'd5,   8'd9, 1'b0);
        do_op(8'd42,  8'd0, 1'b0);
        do_op(8'd0,   8'd255, 1'b0);

        // Backpressure: result held, new operands ignored.
        @(posedge clk);
        #2 out_ready = 1'b0;
        do_op(8'd77, 8'd5, 1'b0);
        hold = model(8'd77, 8'd5, 1'b0);
        repeat (5) begin
            @(posedge clk);
            #2;
            in_valid = 1'b1;
            dividend = W'($urandom);
            divisor  = 8'd3;
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready",  32'(in_ready),  32'd0);
            check("bp_quotient",  32'(quotient),  32'(hold.q));
            check("bp_remainder", 32'(remainder), 32'(hold.r));
        end
        @(posedge clk);
        #2;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("release_out_valid", 32'(out_valid), 32'd0);
        check("release_in_ready",  32'(in_ready),  32'd1);
        do_op(8'd100, 8'd10, 1'b0);

`ifdef DIVIDER_SIGNED_EN
        do_op(8'hF9, 8'd2,  1'b1);
        do_op(8'h80, 8'hFF, 1'b1);
        do_op(8'h80, 8'h00, 1'b1);
        do_op(8'd7,  8'hFE, 1'b1);
`endif

        // Randomized operations under random backpressure.
        rand_bp = 1'b1;
        for (int i = 0; i < 40; i++) begin
            a = W'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : W'($urandom_range(1, 255));
            if ($urandom_range(0, 3) == 0) b = W'($urandom_range(1, 4));
            sgn = 1'b0;
`ifdef DIVIDER_SIGNED_EN
            sgn = 1'($urandom_range(0, 1));
`endif
            do_op(a, b, sgn);
        end
        rand_bp = 1'b0;
        @(posedge clk);
        #3 out_ready = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        check("idle_out_valid",     32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
